// File: rtl/present_pkg.sv
// present_pkg: shared types, widths and key-schedule S-box helpers
// for the iterative PRESENT-80 core.
`default_nettype none

package present_pkg;

   localparam int KEY_W = 80;
   localparam int BLK_W = 64;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      KEYEXP   = 3'd1,
      ENC      = 3'd2,
      DEC_INIT = 3'd3,
      DEC      = 3'd4,
      DONE     = 3'd5
   } present_state_t;

   function automatic logic [3:0] sbox4(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
         4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
         4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
         4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
      endcase
      return y;
   endfunction

   function automatic logic [3:0] inv_sbox4(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
         4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
         4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
         4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
      endcase
      return y;
   endfunction

endpackage

`default_nettype wire

// File: rtl/present_key_sched.sv
// present_key_sched: one step of the PRESENT-80 key schedule,
// forward (dir=0) or its exact inverse (dir=1).
`default_nettype none

module present_key_sched
   import present_pkg::*;
(
   input  logic [KEY_W-1:0] k,
   input  logic [4:0]       cnt,
   input  logic             dir,
   output logic [KEY_W-1:0] k_next
);
   logic [KEY_W-1:0] fwd;
   logic [KEY_W-1:0] inv_x;

   always_comb begin
      fwd          = {k[18:0], k[79:19]};
      fwd[79:76]   = sbox4(fwd[79:76]);
      fwd[19:15]   = fwd[19:15] ^ cnt;

      inv_x        = k;
      inv_x[19:15] = inv_x[19:15] ^ cnt;
      inv_x[79:76] = inv_sbox4(inv_x[79:76]);

      k_next = dir ? {inv_x[60:0], inv_x[79:61]} : fwd;
   end
endmodule

`default_nettype wire

// File: rtl/present_stages.sv
// enc_stage_2 / dec_stage: single combinational PRESENT rounds
// (addRoundKey-sBox-pLayer and its inverse).
`default_nettype none

module enc_stage_2
   import present_pkg::*;
(
   input  logic [BLK_W-1:0] st,
   input  logic [BLK_W-1:0] rk,
   output logic [BLK_W-1:0] st_next
);
   logic [BLK_W-1:0] sb;

   for (genvar n = 0; n < 16; n++) begin : g_sbox
      assign sb[4*n +: 4] = sbox4(st[4*n +: 4] ^ rk[4*n +: 4]);
   end

   // pLayer: bit i moves to 16*(i mod 4) + i/4
   for (genvar i = 0; i < 64; i++) begin : g_perm
      assign st_next[16*(i%4) + i/4] = sb[i];
   end
endmodule

module dec_stage
   import present_pkg::*;
(
   input  logic [BLK_W-1:0] st,
   input  logic [BLK_W-1:0] rk,
   output logic [BLK_W-1:0] st_next
);
   logic [BLK_W-1:0] ip;

   for (genvar i = 0; i < 64; i++) begin : g_iperm
      assign ip[i] = st[16*(i%4) + i/4];
   end

   for (genvar n = 0; n < 16; n++) begin : g_isbox
      assign st_next[4*n +: 4] = inv_sbox4(ip[4*n +: 4]) ^ rk[4*n +: 4];
   end
endmodule

`default_nettype wire

// File: rtl/present_iter_ctrl.sv
// present_iter_ctrl: iterative PRESENT-80 enc/dec core, one round per clock.
// Optional decrypt-key cache enabled by macro PRESENT_DKEY_CACHE_EN.
`default_nettype none

module present_iter_ctrl
   import present_pkg::*;
#(
   parameter int N_ROUNDS = 31
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             mode_i,
   input  logic [BLK_W-1:0] block_i,
   input  logic [KEY_W-1:0] key_i,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BLK_W-1:0] block_o,
   output logic             busy_o
);
   localparam logic [4:0] LAST = 5'(N_ROUNDS);

   present_state_t   state, state_nx;
   logic [BLK_W-1:0] st, st_nx;
   logic [KEY_W-1:0] k, k_nx;
   logic [4:0]       cnt, cnt_nx;
   logic [BLK_W-1:0] blk_q, blk_nx;

   logic [BLK_W-1:0] enc_out, dec_out;
   logic [KEY_W-1:0] ks_out;
   logic [4:0]       ks_cnt;
   logic             ks_dir;
   logic             accept;
   logic             cache_hit;
   logic [KEY_W-1:0] cache_key;

   assign accept = in_valid & in_ready;

   enc_stage_2 u_enc (.st(st), .rk(k[79:16]), .st_next(enc_out));
   dec_stage   u_dec (.st(st), .rk(k[79:16]), .st_next(dec_out));

   present_key_sched u_ks (
      .k      (k),
      .cnt    (ks_cnt),
      .dir    (ks_dir),
      .k_next (ks_out)
   );

`ifdef PRESENT_DKEY_CACHE_EN
   logic             cache_vld;
   logic [KEY_W-1:0] cache_tag;

   assign cache_hit = cache_vld && (cache_tag == key_i);

   // Tag is captured on a miss accept; the entry becomes valid only once
   // the expanded key is available at the end of KEYEXP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cache_vld <= 1'b0;
         cache_tag <= '0;
         cache_key <= '0;
      end else begin
         if (accept && mode_i && !cache_hit) begin
            cache_vld <= 1'b0;
            cache_tag <= key_i;
         end
         if (state == KEYEXP && cnt == LAST) begin
            cache_vld <= 1'b1;
            cache_key <= ks_out;
         end
      end
   end
`else
   assign cache_hit = 1'b0;
   assign cache_key = '0;
`endif

   always_comb begin
      state_nx = state;
      st_nx    = st;
      k_nx     = k;
      cnt_nx   = cnt;
      blk_nx   = blk_q;
      ks_cnt   = cnt;
      ks_dir   = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               st_nx  = block_i;
               k_nx   = key_i;
               cnt_nx = 5'd1;
               if (!mode_i) begin
                  state_nx = ENC;
               end else if (cache_hit) begin
                  k_nx     = cache_key;
                  state_nx = DEC_INIT;
               end else begin
                  state_nx = KEYEXP;
               end
            end
         end
         KEYEXP: begin
            k_nx = ks_out;
            if (cnt == LAST) state_nx = DEC_INIT;
            else             cnt_nx   = cnt + 5'd1;
         end
         ENC: begin
            st_nx = enc_out;
            k_nx  = ks_out;
            if (cnt == LAST) begin
               blk_nx   = enc_out ^ ks_out[79:16];
               state_nx = DONE;
            end else begin
               cnt_nx = cnt + 5'd1;
            end
         end
         DEC_INIT: begin
            st_nx    = st ^ k[79:16];
            ks_dir   = 1'b1;
            ks_cnt   = LAST;
            k_nx     = ks_out;
            cnt_nx   = LAST;
            state_nx = DEC;
         end
         DEC: begin
            st_nx  = dec_out;
            ks_dir = 1'b1;
            ks_cnt = cnt - 5'd1;
            k_nx   = ks_out;
            if (cnt == 5'd1) begin
               blk_nx   = dec_out;
               state_nx = DONE;
            end else begin
               cnt_nx = cnt - 5'd1;
            end
         end
         DONE: begin
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         st    <= '0;
         k     <= '0;
         cnt   <= '0;
         blk_q <= '0;
      end else begin
         state <= state_nx;
         st    <= st_nx;
         k     <= k_nx;
         cnt   <= cnt_nx;
         blk_q <= blk_nx;
      end
   end

   // Gated by rst_n so the core never advertises ready while held in reset.
   assign in_ready  = (state == IDLE) && rst_n;
   assign out_valid = (state == DONE);
   assign busy_o    = (state != IDLE);
   assign block_o   = blk_q;

endmodule

`default_nettype wire

// File: tb/tb_present_iter_ctrl.sv
// tb_present_iter_ctrl: scoreboard bench for present_iter_ctrl against a
// textbook PRESENT-80 reference model.
`default_nettype none

module tb_present_iter_ctrl;
   localparam int NR = 31;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        mode_i = 1'b0;
   logic [63:0] block_i = '0;
   logic [79:0] key_i = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] block_o;
   logic        busy_o;

   always #5 clk = ~clk;

   present_iter_ctrl #(.N_ROUNDS(NR)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .mode_i(mode_i), .block_i(block_i), .key_i(key_i),
      .out_valid(out_valid), .out_ready(out_ready), .block_o(block_o), .busy_o(busy_o)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int acc_cyc = 0;
   logic        prev_ov = 1'b0;
   logic [63:0] held = '0;

   typedef struct { logic [63:0] blk; int lat; } exp_t;
   exp_t exp_q[$];

   bit          mc_vld = 1'b0;
   logic [79:0] mc_tag = '0;

   logic [3:0]  SB [16] = '{4'hC,4'h5,4'h6,4'hB,4'h9,4'h0,4'hA,4'hD,
                            4'h3,4'hE,4'hF,4'h8,4'h4,4'h7,4'h1,4'h2};
   logic [63:0] rk_tab [1:32];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   task automatic timeout(input string name);
      total++;
      bad++;
      $display("FAIL %s: timed out", name);
   endtask

   // ---------------- reference model ----------------
   function automatic void gen_keys(input logic [79:0] key);
      logic [79:0] kk = key;
      for (int r = 1; r <= NR + 1; r++) begin
         rk_tab[r] = kk[79:16];
         kk = {kk[18:0], kk[79:19]};
         kk[79:76] = SB[kk[79:76]];
         kk[19:15] = kk[19:15] ^ 5'(r);
      end
   endfunction

   function automatic int pbit(input int i);
      return (i == 63) ? 63 : (i * 16) % 63;
   endfunction

   function automatic logic [63:0] ref_enc(input logic [63:0] pt, input logic [79:0] key);
      logic [63:0] s = pt;
      logic [63:0] t;
      gen_keys(key);
      for (int r = 1; r <= NR; r++) begin
         s = s ^ rk_tab[r];
         for (int n = 0; n < 16; n++) s[4*n +: 4] = SB[s[4*n +: 4]];
         t = '0;
         for (int i = 0; i < 64; i++) t[pbit(i)] = s[i];
         s = t;
      end
      return s ^ rk_tab[NR + 1];
   endfunction

   function automatic logic [63:0] ref_dec(input logic [63:0] ct, input logic [79:0] key);
      logic [63:0] s;
      logic [63:0] t;
      gen_keys(key);
      s = ct ^ rk_tab[NR + 1];
      for (int r = NR; r >= 1; r--) begin
         t = '0;
         for (int i = 0; i < 64; i++) t[i] = s[pbit(i)];
         s = t;
         for (int n = 0; n < 16; n++)
            for (int j = 0; j < 16; j++)
               if (SB[j] == t[4*n +: 4]) s[4*n +: 4] = 4'(j);
         s = s ^ rk_tab[r];
      end
      return s;
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (!rst_n) begin
         prev_ov = 1'b0;
      end else begin
         if (in_valid && in_ready) acc_cyc = cyc;
         if (in_valid && busy_o) check("no_accept_busy", 64'(in_ready), 64'd0);
         if (out_valid && !prev_ov) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", 64'(out_valid), 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("result", block_o, e.blk);
               check("latency", 64'(cyc - acc_cyc), 64'(e.lat));
            end
            held = block_o;
         end else if (out_valid && prev_ov) begin
            check("stable", block_o, held);
            check("in_ready_low", 64'(in_ready), 64'd0);
         end
         prev_ov = out_valid;
      end
   end

   // ---------------- stimulus ----------------
   task automatic issue(input logic m, input logic [63:0] b, input logic [79:0] key,
                        input logic [63:0] expv, input bit hold_valid);
      exp_t e;
      int   n = 0;
      e.blk = expv;
      if (!m) begin
         e.lat = NR + 1;
      end else begin
         e.lat = 2 * NR + 2;
`ifdef PRESENT_DKEY_CACHE_EN
         if (mc_vld && mc_tag == key) e.lat = NR + 2;
         else begin mc_vld = 1'b1; mc_tag = key; end
`endif
      end
      exp_q.push_back(e);
      mode_i = m; block_i = b; key_i = key; in_valid = 1'b1;
      while (!in_ready && n < 300) begin @(posedge clk); #1; n++; end
      if (!in_ready) timeout("accept_wait");
      @(posedge clk); #1;
      if (hold_valid) begin
         mode_i  = 1'($urandom);
         block_i = {$urandom, $urandom};
         key_i   = {16'($urandom), $urandom, $urandom};
      end else begin
         in_valid = 1'b0;
      end
   endtask

   task automatic finish_op(input int hold);
      int n = 0;
      while (!out_valid && n < 300) begin
         out_ready = 1'($urandom);
         @(posedge clk); #1;
         n++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      if (!out_valid) begin
         timeout("out_valid_wait");
      end else begin
         repeat (hold) begin @(posedge clk); #1; end
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
      end
   endtask

   task automatic check_reset_outputs(input string tag, input logic rdy);
      check({tag, "_in_ready"}, 64'(in_ready), 64'(rdy));
      check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_block_o"}, block_o, 64'd0);
      check({tag, "_busy"}, 64'(busy_o), 64'd0);
   endtask

   initial begin
      logic [63:0] pt, ct;
      logic [79:0] key;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst", 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_outputs("post_rst", 1'b1);
      @(posedge clk); #1;

      issue(1'b0, 64'h0, 80'h0, 64'h5579C1387B228445, 1'b0);
      finish_op(1);
      issue(1'b0, 64'h0, {80{1'b1}}, 64'hE72C46C0F5945049, 1'b1);
      finish_op(0);
      issue(1'b0, {64{1'b1}}, {80{1'b1}}, 64'h3333DCD3213210D2, 1'b0);
      finish_op(2);
      issue(1'b1, 64'hA112FFC72F68417B, 80'h0, {64{1'b1}}, 1'b1);
      finish_op(10);

      // abort an encryption around round 15
      issue(1'b0, 64'h0123456789ABCDEF, 80'h1, 64'h0, 1'b0);
      repeat (15) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      exp_q.delete();
      mc_vld = 1'b0;
      @(negedge clk);
      check_reset_outputs("mid_rst", 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_outputs("mid_post_rst", 1'b1);
      @(posedge clk); #1;
      issue(1'b0, 64'h0, 80'h0, 64'h5579C1387B228445, 1'b0);
      finish_op(0);

      issue(1'b1, 64'hA112FFC72F68417B, 80'h0, {64{1'b1}}, 1'b0);
      finish_op(0);
      issue(1'b1, 64'hA112FFC72F68417B, 80'h0, {64{1'b1}}, 1'b0);
      finish_op(0);
      issue(1'b1, 64'h3333DCD3213210D2, {80{1'b1}}, {64{1'b1}}, 1'b0);
      finish_op(0);

      for (int t = 0; t < 300; t++) begin
         pt  = {$urandom, $urandom};
         key = (t % 5 == 4) ? mc_tag : {16'($urandom), $urandom, $urandom};
         ct  = ref_enc(pt, key);
         check("model_roundtrip", ref_dec(ct, key), pt);
         issue(1'b0, pt, key, ct, 1'($urandom));
         finish_op(int'($urandom_range(0, 3)));
         issue(1'b1, ct, key, pt, 1'($urandom));
         finish_op(int'($urandom_range(0, 3)));
      end

      repeat (3) @(negedge clk);
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
